fp_multiplier: RTL and testbench
================================

# fp_multiplier

Iterative IEEE-754 single-precision multiplier, the multiplicative counterpart of the sequential floating-point divider in the arithmetic datapath. It accepts two operands on a start pulse, forms the 24x24 mantissa product by shift-and-add over 24 cycles, then normalises, truncates and packs the result. The `start`/`busy`/`valid`/`out_reg` handshake matches the divider's, so either unit can sit behind the same controller.

## Interface
- `width`, default 32: operand and result width; 32 is the only supported value.
- `clk`  input  1: clock; all state changes on the rising edge.
- `rst`  input  1: reset, asynchronous, active-low (asserted when 0).
- `start`  input  1: request; sampled only in IDLE.
- `multiplicand`  input  32: operand A, IEEE-754 single; sampled on the accepting edge.
- `multiplier`  input  32: operand B, IEEE-754 single; sampled on the accepting edge.
- `busy`  output  1: high from the accepting edge until the result edge.
- `valid`  output  1: one-cycle pulse; `out_reg` holds a new result.
- `out_reg`  output  32: result; holds its value until the next result or reset.

## Operation
- States: IDLE, INIT, COMPUTE, NORM, FNL.
- **IDLE**
  - `valid` <= 0.
  - If `start` = 1: latch both operands into internal registers, set `busy` <= 1, go to INIT.
- **INIT**
  - Sign = sA ^ sB.
  - Special-case priority (first match wins):
    1. Either operand NaN (exp 255, mantissa != 0), or inf x zero: result 0x7FC00000.
    2. Either operand exp 255: result {sign, 0xFF, 23'b0}.
    3. Either operand exp 0 (zero; denormals flush to zero): result {sign, 31'b0}.
  - Any special case: go to FNL.
  - Otherwise:
    - Load mantissas {1, frac} as 24 bits.
    - Clear the 48-bit accumulator and the iteration counter.
    - Exponent (10-bit signed) = eA + eB − 127.
    - Go to COMPUTE.
- **COMPUTE**: 24 iterations, one per cycle. At iteration i, if B[i] = 1, accumulator += A << i. After the 24th iteration go to NORM.
- **NORM**: truncate (round toward zero); no guard or sticky bits.
  - If acc[47] = 1: frac = acc[46:24], exponent + 1.
  - Else: frac = acc[45:23].
  - If final exponent >= 255: result {sign, 0xFF, 0}.
  - If final exponent <= 0: result {sign, 31'b0}.
- **FNL**: `out_reg` <= result, `valid` <= 1, `busy` <= 0, counter <= 0, go to IDLE.
- `start` while `busy` = 1 is ignored; it is not queued.
- Reset (`rst` = 0) at any time, including mid-COMPUTE:
  - `busy` = 0, `valid` = 0, `out_reg` = 0.
  - All internal registers 0; state IDLE.
  - The in-flight operation is discarded with no `valid`.

## Timing
- Reset values: `busy` 0, `valid` 0, `out_reg` 0x00000000.
- Edge E0 = the edge that samples `start` = 1 in IDLE.
- Normal path:
  - E1: INIT.
  - E2–E25: 24 COMPUTE steps.
  - E26: NORM.
  - E27: FNL; `valid` and the new `out_reg` are visible after E27 (latency 27 cycles).
- Special path: E1 INIT, E2 FNL; latency 2 cycles.
- `busy` is high from after E0 until after the FNL edge.
- `valid` is high for exactly one cycle; IDLE clears it at the next edge.
- The earliest next accept is the edge immediately after FNL: `start` held high gives back-to-back operations with no dead cycle.
- Operand inputs may change freely after E0.

## Test plan
- 0x40000000 x 0x40400000 (2.0 x 3.0) -> `out_reg` 0x40C00000; `valid` pulses one cycle, exactly 27 cycles after E0; `busy` high throughout.
- 0x3FC00000 x 0x3FC00000 (1.5 x 1.5, carry normalisation) -> 0x40100000. Then 0xC0000000 x 0x3F000000 (−2.0 x 0.5) -> 0xBF800000.
- Special cases, each with `valid` 2 cycles after E0:
  - 0x00000000 x 0x40400000 -> 0x00000000.
  - 0x7F800000 x 0x00000000 -> 0x7FC00000.
  - 0xFF800000 x 0x40000000 -> 0xFF800000.
  - 0x7FC00001 x 0x3F800000 -> 0x7FC00000.
- Range limits:
  - 0x7F000000 x 0x7F000000 -> 0x7F800000 (overflow).
  - 0x00800000 x 0x80800000 -> 0x80000000 (underflow, signed zero).
- Handshake:
  - `start` pulsed at cycle 5 of a busy operation: ignored, and the original result is unchanged.
  - `start` held high continuously: second result arrives exactly 28 cycles after the first.
- Reset:
  - Drive `rst` = 0 at cycle 10 of COMPUTE: `busy`, `valid` and `out_reg` go to 0 immediately.
  - After release, 0x3F800000 x 0x3F800000 -> 0x3F800000 with normal 27-cycle latency.

Source files
------------

// File: rtl/fp_multiplier.sv
// Iterative IEEE-754 single-precision multiplier: shift-and-add mantissa product over
// 24 cycles, then normalise, truncate toward zero and pack. Denormals flush to zero.
module fp_multiplier #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] multiplicand,
  input  logic [width-1:0] multiplier,
  output logic             busy,
  output logic             valid,
  output logic [width-1:0] out_reg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_NORM    = 3'd3;
  localparam logic [2:0] S_FNL     = 3'd4;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [2:0]        r_state;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic              r_sign;
  logic signed [9:0] r_exp;
  logic [23:0]       r_ma;
  logic [23:0]       r_mb;
  logic [47:0]       r_acc;
  logic [4:0]        r_cnt;
  logic [31:0]       r_result;

  // Operand field decode (operates on the latched copies)
  logic [7:0]  w_ea;
  logic [7:0]  w_eb;
  logic [22:0] w_fa;
  logic [22:0] w_fb;
  logic        w_sign;
  logic        w_a_max;
  logic        w_b_max;
  logic        w_a_zero;
  logic        w_b_zero;
  logic        w_a_nan;
  logic        w_b_nan;
  logic        w_special;
  logic [31:0] w_special_result;
  logic signed [9:0] w_exp_init;

  assign w_ea     = r_a[30:23];
  assign w_eb     = r_b[30:23];
  assign w_fa     = r_a[22:0];
  assign w_fb     = r_b[22:0];
  assign w_sign   = r_a[31] ^ r_b[31];
  assign w_a_max  = (w_ea == 8'hFF);
  assign w_b_max  = (w_eb == 8'hFF);
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);
  assign w_a_nan  = w_a_max && (w_fa != 23'd0);
  assign w_b_nan  = w_b_max && (w_fb != 23'd0);

  assign w_exp_init = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;

  // First match wins: NaN or inf*zero, then infinity, then zero
  always_comb begin
    w_special        = 1'b1;
    w_special_result = 32'd0;
    if (w_a_nan || w_b_nan || (w_a_max && w_b_zero) || (w_b_max && w_a_zero)) begin
      w_special_result = QNAN;
    end else if (w_a_max || w_b_max) begin
      w_special_result = {w_sign, 8'hFF, 23'd0};
    end else if (w_a_zero || w_b_zero) begin
      w_special_result = {w_sign, 31'd0};
    end else begin
      w_special = 1'b0;
    end
  end

  // One partial product per iteration, selected by bit r_cnt of the multiplier mantissa
  logic [47:0] w_partial;
  assign w_partial = r_mb[r_cnt] ? ({24'd0, r_ma} << r_cnt) : 48'd0;

  logic              w_carry;
  logic [22:0]       w_frac;
  logic signed [9:0] w_exp_final;
  logic [31:0]       w_norm_result;

  assign w_carry     = r_acc[47];
  assign w_frac      = w_carry ? r_acc[46:24] : r_acc[45:23];
  assign w_exp_final = r_exp + (w_carry ? 10'sd1 : 10'sd0);

  always_comb begin
    w_norm_result = {r_sign, w_exp_final[7:0], w_frac};
    if (w_exp_final >= 10'sd255) begin
      w_norm_result = {r_sign, 8'hFF, 23'd0};
    end else if (w_exp_final <= 10'sd0) begin
      w_norm_result = {r_sign, 31'd0};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_sign   <= 1'b0;
      r_exp    <= 10'sd0;
      r_ma     <= 24'd0;
      r_mb     <= 24'd0;
      r_acc    <= 48'd0;
      r_cnt    <= 5'd0;
      r_result <= 32'd0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      out_reg  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          valid <= 1'b0;
          if (start) begin
            r_a     <= multiplicand;
            r_b     <= multiplier;
            busy    <= 1'b1;
            r_state <= S_INIT;
          end
        end
        S_INIT: begin
          r_sign <= w_sign;
          if (w_special) begin
            r_result <= w_special_result;
            r_state  <= S_FNL;
          end else begin
            r_ma    <= {1'b1, w_fa};
            r_mb    <= {1'b1, w_fb};
            r_acc   <= 48'd0;
            r_cnt   <= 5'd0;
            r_exp   <= w_exp_init;
            r_state <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          r_acc <= r_acc + w_partial;
          if (r_cnt == 5'd23) begin
            r_state <= S_NORM;
          end else begin
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_NORM: begin
          r_result <= w_norm_result;
          r_state  <= S_FNL;
        end
        S_FNL: begin
          out_reg <= r_result;
          valid   <= 1'b1;
          busy    <= 1'b0;
          r_cnt   <= 5'd0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_multiplier.sv
// Directed self-checking bench for fp_multiplier: arithmetic, specials, range limits,
// handshake and asynchronous reset behaviour.
module tb_fp_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        valid;
  logic [31:0] out_reg;

  int checks = 0;
  int errors = 0;

  fp_multiplier #(.width(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .valid        (valid),
    .out_reg      (out_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and wait (bounded) for valid; lat = -1 on timeout
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit busy_ok);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    lat     = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        lat = c;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    res = out_reg;
    $display("op %08h x %08h -> %08h latency %0d", a, b, res, lat);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    multiplicand = 32'd0;
    multiplier = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (out_reg !== 32'd0) begin errors++; $display("FAIL reset_out got %08h want 00000000", out_reg); end
    @(negedge clk);
    rst = 1'b1;
    $display("reset released");
  endtask

  task automatic test_basic();
    logic [31:0] res;
    int lat;
    bit bok;
    run_op(32'h40000000, 32'h40400000, res, lat, bok);
    checks++; if (res !== 32'h40C00000) begin errors++; $display("FAIL basic_result got %08h want 40C00000", res); end
    checks++; if (lat !== 27) begin errors++; $display("FAIL basic_latency got %0d want 27", lat); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL basic_busy got dropped want held"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b want 0", busy); end
    @(posedge clk);
    #1;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %b want 0", valid); end
  endtask

  task automatic test_normalise();
    logic [31:0] res;
    int lat;
    bit bok;
    run_op(32'h3FC00000, 32'h3FC00000, res, lat, bok);
    checks++; if (res !== 32'h40100000) begin errors++; $display("FAIL carry_result got %08h want 40100000", res); end
    checks++; if (lat !== 27) begin errors++; $display("FAIL carry_latency got %0d want 27", lat); end
    run_op(32'hC0000000, 32'h3F000000, res, lat, bok);
    checks++; if (res !== 32'hBF800000) begin errors++; $display("FAIL neg_result got %08h want BF800000", res); end
  endtask

  task automatic test_special();
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [31:0] te [4];
    logic [31:0] res;
    int lat;
    bit bok;
    ta[0] = 32'h00000000; tb[0] = 32'h40400000; te[0] = 32'h00000000;
    ta[1] = 32'h7F800000; tb[1] = 32'h00000000; te[1] = 32'h7FC00000;
    ta[2] = 32'hFF800000; tb[2] = 32'h40000000; te[2] = 32'hFF800000;
    ta[3] = 32'h7FC00001; tb[3] = 32'h3F800000; te[3] = 32'h7FC00000;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], res, lat, bok);
      checks++; if (res !== te[i]) begin errors++; $display("FAIL special%0d_result got %08h want %08h", i, res, te[i]); end
      checks++; if (lat !== 2) begin errors++; $display("FAIL special%0d_latency got %0d want 2", i, lat); end
    end
  endtask

  task automatic test_range();
    logic [31:0] res;
    int lat;
    bit bok;
    run_op(32'h7F000000, 32'h7F000000, res, lat, bok);
    checks++; if (res !== 32'h7F800000) begin errors++; $display("FAIL overflow got %08h want 7F800000", res); end
    run_op(32'h00800000, 32'h80800000, res, lat, bok);
    checks++; if (res !== 32'h80000000) begin errors++; $display("FAIL underflow got %08h want 80000000", res); end
    checks++; if (lat !== 27) begin errors++; $display("FAIL underflow_latency got %0d want 27", lat); end
  endtask

  task automatic test_start_ignored();
    int lat;
    int extra;
    @(negedge clk);
    multiplicand = 32'h40000000;
    multiplier   = 32'h40400000;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) begin
        start        = 1'b1;
        multiplicand = 32'h3F800000;
        multiplier   = 32'h3F800000;
      end else begin
        start = 1'b0;
      end
      if (valid) begin
        lat = c;
        break;
      end
    end
    $display("busy start pulse: result %08h latency %0d", out_reg, lat);
    checks++; if (out_reg !== 32'h40C00000) begin errors++; $display("FAIL ignored_result got %08h want 40C00000", out_reg); end
    checks++; if (lat !== 27) begin errors++; $display("FAIL ignored_latency got %0d want 27", lat); end
    extra = 0;
    repeat (35) begin
      @(posedge clk);
      #1;
      if (valid || busy) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignored_not_queued got %0d active cycles want 0", extra); end
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    logic [31:0] r1;
    logic [31:0] r2;
    t1 = -1; t2 = -1; r1 = 32'd0; r2 = 32'd0;
    @(negedge clk);
    multiplicand = 32'h3FC00000;
    multiplier   = 32'h3FC00000;
    start        = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        if (t1 < 0) begin
          t1 = c; r1 = out_reg;
        end else begin
          t2 = c; r2 = out_reg;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    $display("back-to-back: first %08h at %0d, second %08h at %0d", r1, t1, r2, t2);
    checks++; if (t1 !== 27) begin errors++; $display("FAIL b2b_first_latency got %0d want 27", t1); end
    checks++; if (t2 - t1 !== 28) begin errors++; $display("FAIL b2b_spacing got %0d want 28", t2 - t1); end
    checks++; if (r2 !== 32'h40100000) begin errors++; $display("FAIL b2b_second_result got %08h want 40100000", r2); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_midway();
    logic [31:0] res;
    int lat;
    int seen;
    bit bok;
    @(negedge clk);
    multiplicand = 32'h40000000;
    multiplier   = 32'h40400000;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    $display("mid-compute reset: busy %b valid %b out %08h", busy, valid, out_reg);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", valid); end
    checks++; if (out_reg !== 32'd0) begin errors++; $display("FAIL midreset_out got %08h want 00000000", out_reg); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (valid || busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_discard got %0d active cycles want 0", seen); end
    run_op(32'h3F800000, 32'h3F800000, res, lat, bok);
    checks++; if (res !== 32'h3F800000) begin errors++; $display("FAIL postreset_result got %08h want 3F800000", res); end
    checks++; if (lat !== 27) begin errors++; $display("FAIL postreset_latency got %0d want 27", lat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_normalise();
    test_special();
    test_range();
    test_start_ignored();
    test_back_to_back();
    test_reset_midway();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
